// File: rtl/router_input_unit.sv
// router_input_unit: NoC input port with flit FIFO, XY routing and request/grant forwarding
module router_input_unit #(
  parameter int FlitWidth = 34,
  parameter int Depth     = 4,
  parameter int XWidth    = 3,
  parameter int YWidth    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XWidth-1:0]    position_x,
  input  logic [YWidth-1:0]    position_y,
  input  logic [FlitWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4:0]           request,
  input  logic [4:0]           grant,
  input  logic [4:0]           out_ready,
  output logic [FlitWidth-1:0] out_data,
  output logic                 forwarding_head,
  output logic                 forwarding_tail,
  output logic                 protocol_error
);
  localparam int AW = $clog2(Depth);
  localparam logic WAIT_HEAD = 1'b0;
  localparam logic IN_PACKET = 1'b1;
  logic [FlitWidth-1:0] mem_q [Depth];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic state_q, state_d;
  logic [4:0] route_q, route_d, route;
  logic perr_q, perr_d;
  logic empty, full, push, pop, fire, drop, is_head, is_tail;
  logic [XWidth-1:0] dest_x;
  logic [YWidth-1:0] dest_y;
  assign empty    = wr_ptr_q == rd_ptr_q;
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign out_data = mem_q[rd_ptr_q[AW-1:0]];
  assign is_head  = out_data[FlitWidth-1];
  assign is_tail  = out_data[FlitWidth-2];
  assign dest_x   = out_data[XWidth-1:0];
  assign dest_y   = out_data[XWidth+YWidth-1:XWidth];
  assign protocol_error = perr_q;
  // XY route of the flit currently at the FIFO head
  always_comb begin
    route = dest_x > position_x ? 5'b01000 :
            dest_x < position_x ? 5'b00100 :
            dest_y > position_y ? 5'b00010 :
            dest_y < position_y ? 5'b00001 : 5'b10000;
  end
  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end
  // state register: FSM state, pointers, latched route and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WAIT_HEAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      route_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      route_q  <= route_d;
      perr_q   <= perr_d;
    end
  end
  // next-state: packet framing, pointer advance, route latch on head fire
  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    wr_ptr_d = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
    perr_d   = perr_q | drop;
    if (state_q == WAIT_HEAD && fire && !is_tail) begin
      state_d = IN_PACKET;
      route_d = route;
    end else if (state_q == IN_PACKET && fire && is_tail) begin
      state_d = WAIT_HEAD;
    end
  end
  // outputs: request held at route_q mid-packet, stray body flits dropped while waiting for a head
  always_comb begin
    request = state_q == IN_PACKET ? route_q : (!empty && is_head) ? route : 5'b0;
    fire    = !empty && |(request & grant & out_ready);
    drop    = state_q == WAIT_HEAD && !empty && !is_head;
    pop     = fire | drop;
    forwarding_head = fire && is_head && state_q == WAIT_HEAD;
    forwarding_tail = fire && is_tail;
  end
endmodule

// File: tb/tb_router_input_unit.sv
// tb_router_input_unit: table-driven and directed checks for router_input_unit
module tb_router_input_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] position_x = 3'd2, position_y = 3'd2;
  logic [33:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4:0] request, grant = '0, out_ready = 5'h1f;
  logic [33:0] out_data;
  logic forwarding_head, forwarding_tail, protocol_error;
  int total = 0, passed = 0;

  typedef struct {
    logic [33:0] din;
    logic        vin;
    logic [4:0]  gnt;
    logic [4:0]  ordy;
    logic        e_rdy;
    logic [4:0]  e_req;
    logic        e_fh;
    logic        e_ft;
    logic        e_perr;
    logic        chk_d;
    logic [33:0] e_d;
  } vec_t;
  vec_t vecs[$];

  router_input_unit dut (
    .clk(clk), .rst(rst), .position_x(position_x), .position_y(position_y),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .request(request),
    .grant(grant), .out_ready(out_ready), .out_data(out_data),
    .forwarding_head(forwarding_head), .forwarding_tail(forwarding_tail),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] mk(input logic h, input logic t, input logic [2:0] x, input logic [2:0] y, input logic [25:0] pl);
    return {h, t, pl, y, x};
  endfunction

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input logic [33:0] din, input logic vin, input logic [4:0] gnt, input logic [4:0] ordy,
                     input logic rdy, input logic [4:0] req, input logic fh, input logic ft, input logic perr,
                     input logic cd, input logic [33:0] ed);
    vec_t v;
    v.din = din; v.vin = vin; v.gnt = gnt; v.ordy = ordy; v.e_rdy = rdy; v.e_req = req;
    v.e_fh = fh; v.e_ft = ft; v.e_perr = perr; v.chk_d = cd; v.e_d = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [33:0] d, input logic v, input logic [4:0] g);
    @(negedge clk);
    in_data = d; in_valid = v; grant = g; out_ready = 5'h1f;
    #1;
  endtask

  logic [33:0] f1, n_h, n_b, n_t, l_h, l_b1, l_b2, l_b3, l_t, bad, s_h, s_b, s_t, w_h;

  initial begin
    f1   = mk(1, 1, 5, 1, 26'h11);
    n_h  = mk(1, 0, 2, 0, 26'h21);
    n_b  = mk(0, 0, 0, 0, 26'h22);
    n_t  = mk(0, 1, 0, 0, 26'h23);
    l_h  = mk(1, 0, 2, 2, 26'h31);
    l_b1 = mk(0, 0, 0, 0, 26'h32);
    l_b2 = mk(0, 0, 0, 0, 26'h33);
    l_b3 = mk(0, 0, 0, 0, 26'h34);
    l_t  = mk(0, 1, 0, 0, 26'h35);
    bad  = mk(0, 0, 0, 0, 26'h41);
    s_h  = mk(1, 0, 2, 3, 26'h51);
    s_b  = mk(1, 0, 0, 2, 26'h52);
    s_t  = mk(0, 1, 0, 0, 26'h53);
    w_h  = mk(1, 1, 0, 2, 26'h61);
    // single-flit packet to East
    add(f1,   1, 5'h00, 5'h1f, 1, 5'h00, 0, 0, 0, 0, '0);
    add('0,   0, 5'h08, 5'h1f, 1, 5'h08, 1, 1, 0, 1, f1);
    add('0,   0, 5'h00, 5'h1f, 1, 5'h00, 0, 0, 0, 0, '0);
    // 3-flit North packet, grant withheld / wrong port / out_ready low
    add(n_h,  1, 5'h00, 5'h1f, 1, 5'h00, 0, 0, 0, 0, '0);
    add(n_b,  1, 5'h1e, 5'h1f, 1, 5'h01, 0, 0, 0, 1, n_h);
    add(n_t,  1, 5'h01, 5'h1e, 1, 5'h01, 0, 0, 0, 1, n_h);
    add('0,   0, 5'h01, 5'h1f, 1, 5'h01, 1, 0, 0, 1, n_h);
    add('0,   0, 5'h01, 5'h1f, 1, 5'h01, 0, 0, 0, 1, n_b);
    add('0,   0, 5'h01, 5'h1f, 1, 5'h01, 0, 1, 0, 1, n_t);
    add('0,   0, 5'h00, 5'h1f, 1, 5'h00, 0, 0, 0, 0, '0);
    // fill FIFO, refuse 5th push, drain Local with wrap-around
    add(l_h,  1, 5'h00, 5'h1f, 1, 5'h00, 0, 0, 0, 0, '0);
    add(l_b1, 1, 5'h00, 5'h1f, 1, 5'h10, 0, 0, 0, 1, l_h);
    add(l_b2, 1, 5'h00, 5'h1f, 1, 5'h10, 0, 0, 0, 1, l_h);
    add(l_b3, 1, 5'h00, 5'h1f, 1, 5'h10, 0, 0, 0, 1, l_h);
    add(l_t,  1, 5'h00, 5'h1f, 0, 5'h10, 0, 0, 0, 1, l_h);
    add(l_t,  1, 5'h10, 5'h1f, 0, 5'h10, 1, 0, 0, 1, l_h);
    add(l_t,  1, 5'h10, 5'h1f, 1, 5'h10, 0, 0, 0, 1, l_b1);
    add('0,   0, 5'h10, 5'h1f, 1, 5'h10, 0, 0, 0, 1, l_b2);
    add('0,   0, 5'h10, 5'h1f, 1, 5'h10, 0, 0, 0, 1, l_b3);
    add('0,   0, 5'h10, 5'h1f, 1, 5'h10, 0, 1, 0, 1, l_t);
    add('0,   0, 5'h00, 5'h1f, 1, 5'h00, 0, 0, 0, 0, '0);
    // stray body flit while waiting for a head
    add(bad,  1, 5'h00, 5'h1f, 1, 5'h00, 0, 0, 0, 0, '0);
    add('0,   0, 5'h00, 5'h1f, 1, 5'h00, 0, 0, 0, 1, bad);
    add('0,   0, 5'h00, 5'h1f, 1, 5'h00, 0, 0, 1, 0, '0);
    // South packet draining empty between flits, then West head
    add(s_h,  1, 5'h02, 5'h1f, 1, 5'h00, 0, 0, 1, 0, '0);
    add('0,   0, 5'h02, 5'h1f, 1, 5'h02, 1, 0, 1, 1, s_h);
    add('0,   0, 5'h02, 5'h1f, 1, 5'h02, 0, 0, 1, 0, '0);
    add(s_b,  1, 5'h00, 5'h1f, 1, 5'h02, 0, 0, 1, 0, '0);
    add('0,   0, 5'h02, 5'h1f, 1, 5'h02, 0, 0, 1, 1, s_b);
    add('0,   0, 5'h02, 5'h1f, 1, 5'h02, 0, 0, 1, 0, '0);
    add(s_t,  1, 5'h00, 5'h1f, 1, 5'h02, 0, 0, 1, 0, '0);
    add(w_h,  1, 5'h02, 5'h1f, 1, 5'h02, 0, 1, 1, 1, s_t);
    add('0,   0, 5'h04, 5'h1f, 1, 5'h04, 1, 1, 1, 1, w_h);
    add('0,   0, 5'h00, 5'h1f, 1, 5'h00, 0, 0, 1, 0, '0);

    // reset state
    #12;
    chk("rst_in_ready", 34'(in_ready), 34'(1'b1));
    chk("rst_request", 34'(request), 34'(5'h00));
    chk("rst_perr", 34'(protocol_error), 34'(1'b0));
    chk("rst_pulses", 34'({forwarding_head, forwarding_tail}), 34'(2'b00));
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      in_data = vecs[i].din; in_valid = vecs[i].vin; grant = vecs[i].gnt; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 34'(in_ready), 34'(vecs[i].e_rdy));
      chk($sformatf("v%0d_request", i), 34'(request), 34'(vecs[i].e_req));
      chk($sformatf("v%0d_fwd_head", i), 34'(forwarding_head), 34'(vecs[i].e_fh));
      chk($sformatf("v%0d_fwd_tail", i), 34'(forwarding_tail), 34'(vecs[i].e_ft));
      chk($sformatf("v%0d_perr", i), 34'(protocol_error), 34'(vecs[i].e_perr));
      if (vecs[i].chk_d) chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_d);
    end

    // asynchronous reset in the middle of a packet
    drive(n_h, 1, 5'h00);
    drive(n_b, 1, 5'h00);
    drive(n_t, 1, 5'h00);
    drive('0, 0, 5'h01);
    chk("mid_head_fire", 34'(forwarding_head), 34'(1'b1));
    drive('0, 0, 5'h00);
    chk("mid_req_held", 34'(request), 34'(5'h01));
    grant = 5'h1f;
    #2 rst = 1'b0;
    #1;
    chk("arst_request", 34'(request), 34'(5'h00));
    chk("arst_pulses", 34'({forwarding_head, forwarding_tail}), 34'(2'b00));
    chk("arst_perr", 34'(protocol_error), 34'(1'b0));
    chk("arst_in_ready", 34'(in_ready), 34'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive('0, 0, 5'h1f);
      chk($sformatf("post_rst%0d_req", k), 34'(request), 34'(5'h00));
      chk($sformatf("post_rst%0d_pulses", k), 34'({forwarding_head, forwarding_tail}), 34'(2'b00));
    end
    drive(f1, 1, 5'h00);
    drive('0, 0, 5'h08);
    chk("post_rst_single_req", 34'(request), 34'(5'h08));
    chk("post_rst_single_pulses", 34'({forwarding_head, forwarding_tail}), 34'(2'b11));
    chk("post_rst_single_data", out_data, f1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/router_input_unit.md
Name: router_input_unit

Overview:
- Input-port unit of the NoC router. It sits upstream of the per-output-port arbiters and is the requesting side of their request/grant/head/tail protocol.
- Buffers incoming flits in a FIFO and computes the XY route from the head flit.
- Drives a one-hot request that stays stable for the whole packet, forwards flits on grant, and emits forwarding_head/forwarding_tail pulses to the arbiters.

Parameters:
FlitWidth, 34, total flit width; bit FlitWidth-1 = head marker, bit FlitWidth-2 = tail marker
Depth, 4, FIFO entries; power of 2, >= 2
XWidth, 3, destination/position X coordinate width
YWidth, 3, destination/position Y coordinate width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
position_x  in  XWidth  this router's X coordinate; static
position_y  in  YWidth  this router's Y coordinate; static
in_data  in  FlitWidth  incoming flit
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept; transfer when in_valid & in_ready
request  out  5  one-hot or zero target output: [0]=North, [1]=South, [2]=West, [3]=East, [4]=Local
grant  in  5  grant bit for this input from each output arbiter
out_ready  in  5  downstream space per output port
out_data  out  FlitWidth  flit at FIFO head
forwarding_head  out  1  head flit forwarded this cycle
forwarding_tail  out  1  tail flit forwarded this cycle
protocol_error  out  1  sticky: non-head flit found when a head was expected

Behaviour:
- Reset is asynchronous active-low (rst=0). It clears FIFO pointers and count, sets state WAIT_HEAD, clears route_q and protocol_error.
- During and after reset: in_ready=1, request=0, forwarding_head=0, forwarding_tail=0, protocol_error=0.
- FIFO:
  - Pointers carry a wrap bit; empty when pointers are equal, full when they differ only in the wrap bit.
  - in_ready = ~full. A push while full is refused even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - A flit written in cycle N is visible at the head in cycle N+1. out_data = mem[rd_ptr] (fall-through, no register).
- Head fields (head flit): dest_x = flit[XWidth-1:0], dest_y = flit[XWidth+YWidth-1:XWidth].
- Route (XY, unsigned compare):
  - dest_x > position_x -> East
  - dest_x < position_x -> West
  - else dest_y > position_y -> South
  - else dest_y < position_y -> North
  - else Local
- fire = ~empty & |(request & grant & out_ready).
- On fire: pop, forwarding_head = fire & head bit, forwarding_tail = fire & tail bit.
- State WAIT_HEAD:
  - Empty: request=0.
  - Head flit at FIFO head: request = computed route, combinational with zero delay.
  - Fire on a head without tail: latch route_q, go to IN_PACKET.
  - Fire on a head with tail (single-flit packet): both pulses asserted, stay in WAIT_HEAD.
  - Non-head flit at FIFO head: request=0, flit popped (dropped) that cycle, protocol_error set sticky until reset.
- State IN_PACKET:
  - request = route_q, held even while the FIFO is empty, so the arbiter sees a stable request.
  - A head marker on a body flit is ignored; the flit is forwarded as body.
  - Fire on a tail flit: forwarding_tail=1, go to WAIT_HEAD. Next cycle, request reflects the next head, if present.
- Grant is accepted only on the bit matching request. A grant on a non-requested port has no effect.
- Reset mid-packet discards FIFO contents and state; no pulses are emitted.

Test Plan:
- Position (2,2), push single flit head=1, tail=1, dest (5,1); grant=5'b01000, out_ready=5'b11111 -> request=5'b01000 one cycle after push; forwarding_head=forwarding_tail=1 in the same cycle; FIFO empty after.
- Position (2,2), 3-flit packet dest (2,0) with grant withheld for 2 cycles -> request=5'b00001 held constant throughout; head pulse on the first fire, tail pulse on the third; no pulses while grant=0.
- Depth=4, push 5 flits with no grant -> in_ready=0 after the 4th; the 5th is held by the source. Then grant Local for dest (2,2): 4 pops in 4 cycles, in_ready=1 after the first pop, wrap-around data order preserved.
- Body flit (head=0) pushed while in WAIT_HEAD -> dropped, request stays 0, protocol_error=1 and stays 1 until rst=0.
- Packet in progress with FIFO draining empty between body flits -> request stays at route_q; forwarding_tail fires exactly once. A following head to West gives request=5'b00100 on the next cycle.
- Assert rst=0 mid-packet asynchronously -> request, pulses and protocol_error go 0 immediately; in_ready=1; prior flits are not forwarded after reset release.
